// File: rtl/cdc_sync_filter_pkg.sv
// cdc_sync_filter_pkg: parameter range limits shared by the synchroniser blocks
package cdc_sync_filter_pkg;
  localparam int SYNC_FF_MIN = 2;
  localparam int SYNC_FF_MAX = 10;
  localparam int FILTER_CNT_MAX = 255;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/cdc_filter_chan.sv
// cdc_filter_chan: one channel of synchroniser chain, glitch filter and edge pulses
module cdc_filter_chan
  import cdc_sync_filter_pkg::*;
#(
  parameter int DEST_SYNC_FF = 2,
  parameter int FILTER_CNT = 4,
  parameter logic INIT = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_rst,
  input  logic filt_en,
  input  logic src_in,
  output logic dest_out,
  output logic dest_rise,
  output logic dest_fall,
  output logic accept
);
  localparam int CNT_W = $clog2(FILTER_CNT + 1);
  if (DEST_SYNC_FF < SYNC_FF_MIN || DEST_SYNC_FF > SYNC_FF_MAX) begin : g_bad_sync
    $error("cdc_filter_chan: DEST_SYNC_FF out of range");
  end
  if (FILTER_CNT < 1 || FILTER_CNT > FILTER_CNT_MAX) begin : g_bad_cnt
    $error("cdc_filter_chan: FILTER_CNT out of range");
  end
  logic [DEST_SYNC_FF-1:0] sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] cnt_inc;
  logic [CNT_W:0] eff_cnt;
  logic s;
  assign s = sync_q[DEST_SYNC_FF-1];
  // accept a mismatching level once it has been seen for EFF_CNT consecutive cycles
  always_comb begin
    cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    eff_cnt = filt_en ? (CNT_W+1)'(FILTER_CNT) : (CNT_W+1)'(1);
    accept = (s != dest_out) && (cnt_inc >= eff_cnt);
  end
  // sync chain, stability counter, filtered level and its registered edge pulses
  always_ff @(posedge dest_clk) begin
    if (dest_rst) begin
      sync_q <= {DEST_SYNC_FF{INIT}};
      cnt <= '0;
      dest_out <= INIT;
      dest_rise <= 1'b0;
      dest_fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[DEST_SYNC_FF-2:0], src_in};
      cnt <= (s == dest_out || accept) ? '0 : cnt_inc[CNT_W-1:0];
      dest_out <= accept ? s : dest_out;
      dest_rise <= accept & s;
      dest_fall <= accept & ~s;
    end
  end
endmodule

// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: multi-channel synchroniser with glitch filter and edge events
module cdc_sync_filter
  import cdc_sync_filter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEST_SYNC_FF = 2,
  parameter int FILTER_CNT = 4,
  parameter logic INIT = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_rst,
  input  logic filt_en,
  input  logic [WIDTH-1:0] src_in,
  output logic [WIDTH-1:0] dest_out,
  output logic [WIDTH-1:0] dest_rise,
  output logic [WIDTH-1:0] dest_fall,
  output logic dest_evt
);
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("cdc_sync_filter: WIDTH out of range");
  end
  logic [WIDTH-1:0] accept;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    cdc_filter_chan #(
      .DEST_SYNC_FF(DEST_SYNC_FF),
      .FILTER_CNT(FILTER_CNT),
      .INIT(INIT)
    ) u_chan (
      .dest_clk(dest_clk),
      .dest_rst(dest_rst),
      .filt_en(filt_en),
      .src_in(src_in[i]),
      .dest_out(dest_out[i]),
      .dest_rise(dest_rise[i]),
      .dest_fall(dest_fall[i]),
      .accept(accept[i])
    );
  end
  // summary event, registered on the same edge as the per-channel pulses
  always_ff @(posedge dest_clk) begin
    if (dest_rst) dest_evt <= 1'b0;
    else dest_evt <= |accept;
  end
endmodule

// File: tb/tb_cdc_sync_filter.sv
// tb_cdc_sync_filter: directed self-checking bench for cdc_sync_filter
module tb_cdc_sync_filter;
  logic dest_clk = 1'b0;
  logic dest_rst;
  logic filt_en;
  logic [3:0] src_in;
  logic [3:0] dest_out;
  logic [3:0] dest_rise;
  logic [3:0] dest_fall;
  logic dest_evt;
  int tests = 0;
  int fails = 0;

  cdc_sync_filter #(.WIDTH(4), .DEST_SYNC_FF(2), .FILTER_CNT(4), .INIT(1'b0)) dut (
    .dest_clk(dest_clk),
    .dest_rst(dest_rst),
    .filt_en(filt_en),
    .src_in(src_in),
    .dest_out(dest_out),
    .dest_rise(dest_rise),
    .dest_fall(dest_fall),
    .dest_evt(dest_evt)
  );

  always #5 dest_clk = ~dest_clk;

  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] v);
    src_in = v;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    dest_rst = 1'b1;
    filt_en = 1'b1;
    src_in = 4'hF;
    for (int n = 0; n < 3; n++) begin
      tick();
      tests++;
      if (dest_out !== 4'h0 || dest_rise !== 4'h0 || dest_fall !== 4'h0 || dest_evt !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: out=%h rise=%h fall=%h evt=%b, want 0", n, dest_out, dest_rise, dest_fall, dest_evt);
      end
    end
    dest_rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      tests++;
      if (n < 6 && (dest_out !== 4'h0 || dest_rise !== 4'h0 || dest_evt !== 1'b0)) begin
        fails++;
        $display("FAIL reset_release e%0d: out=%h rise=%h evt=%b, want 0", n, dest_out, dest_rise, dest_evt);
      end
      if (n == 6 && (dest_out !== 4'hF || dest_rise !== 4'hF || dest_fall !== 4'h0 || dest_evt !== 1'b1)) begin
        fails++;
        $display("FAIL reset_accept e6: out=%h rise=%h fall=%h evt=%b, want F F 0 1", dest_out, dest_rise, dest_fall, dest_evt);
      end
      if (n == 7 && (dest_out !== 4'hF || dest_rise !== 4'h0 || dest_evt !== 1'b0)) begin
        fails++;
        $display("FAIL reset_pulse_once e7: out=%h rise=%h evt=%b, want F 0 0", dest_out, dest_rise, dest_evt);
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    settle(4'h0);
    src_in = 4'b0001;
    repeat (3) tick();
    src_in = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      tick();
      tests++;
      if (dest_out[0] !== 1'b0 || dest_rise[0] !== 1'b0 || dest_evt !== 1'b0) begin
        fails++;
        $display("FAIL glitch3 t%0d: out0=%b rise0=%b evt=%b, want 0", n, dest_out[0], dest_rise[0], dest_evt);
      end
    end
    rises = 0;
    src_in = 4'b0001;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 4) src_in = 4'b0000;
      if (dest_rise[0] === 1'b1) rises++;
      if (n == 5) begin
        tests++;
        if (dest_out[0] !== 1'b0) begin
          fails++;
          $display("FAIL glitch4_early e5: out0=%b, want 0", dest_out[0]);
        end
      end
      if (n == 6) begin
        tests++;
        if (dest_out[0] !== 1'b1 || dest_rise[0] !== 1'b1) begin
          fails++;
          $display("FAIL glitch4_accept e6: out0=%b rise0=%b, want 1 1", dest_out[0], dest_rise[0]);
        end
      end
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL glitch4_rise_count: got %0d, want 1", rises);
    end
  endtask

  task automatic test_restart();
    logic [7:0] pat;
    int rises;
    pat = 8'b1111_0111;
    settle(4'h0);
    rises = 0;
    for (int n = 1; n <= 12; n++) begin
      src_in = (n <= 8) ? {2'b00, pat[n-1], 1'b0} : 4'b0010;
      tick();
      if (dest_rise[1] === 1'b1) rises++;
      tests++;
      if (dest_out[1] !== (n >= 10)) begin
        fails++;
        $display("FAIL restart e%0d: out1=%b, want %b", n, dest_out[1], n >= 10);
      end
      if (n == 10) begin
        tests++;
        if (dest_rise[1] !== 1'b1) begin
          fails++;
          $display("FAIL restart_rise e10: rise1=%b, want 1", dest_rise[1]);
        end
      end
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL restart_rise_count: got %0d, want 1", rises);
    end
  endtask

  task automatic test_bypass();
    logic v;
    settle(4'h0);
    filt_en = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      src_in = {1'b0, n[0], 2'b00};
      tick();
      if (n >= 3) begin
        v = (n - 2) % 2 == 1;
        tests++;
        if (dest_out[2] !== v || dest_rise[2] !== v || dest_fall[2] !== !v || dest_evt !== 1'b1) begin
          fails++;
          $display("FAIL bypass e%0d: out2=%b rise2=%b fall2=%b evt=%b, want %b %b %b 1", n, dest_out[2], dest_rise[2], dest_fall[2], dest_evt, v, v, !v);
        end
      end
    end
    filt_en = 1'b1;
    for (int n = 11; n <= 18; n++) begin
      src_in = {1'b0, n[0], 2'b00};
      tick();
      tests++;
      if (dest_out[2] !== 1'b0 || dest_rise[2] !== 1'b0 || dest_fall[2] !== 1'b0) begin
        fails++;
        $display("FAIL filter_on e%0d: out2=%b rise2=%b fall2=%b, want 0", n, dest_out[2], dest_rise[2], dest_fall[2]);
      end
    end
    src_in = 4'h0;
  endtask

  task automatic test_multi();
    settle(4'h0);
    src_in = 4'b1010;
    for (int n = 1; n <= 7; n++) begin
      tick();
      tests++;
      if (n == 6) begin
        if (dest_out !== 4'b1010 || dest_rise !== 4'b1010 || dest_fall !== 4'b0000 || dest_evt !== 1'b1) begin
          fails++;
          $display("FAIL multi_rise e6: out=%b rise=%b fall=%b evt=%b, want 1010 1010 0000 1", dest_out, dest_rise, dest_fall, dest_evt);
        end
      end else if (dest_evt !== 1'b0 || dest_rise !== 4'b0000) begin
        fails++;
        $display("FAIL multi_rise_quiet e%0d: rise=%b evt=%b, want 0", n, dest_rise, dest_evt);
      end
    end
    src_in = 4'b0110;
    for (int n = 1; n <= 7; n++) begin
      tick();
      tests++;
      if (n == 6) begin
        if (dest_out !== 4'b0110 || dest_rise !== 4'b0100 || dest_fall !== 4'b1000 || dest_evt !== 1'b1) begin
          fails++;
          $display("FAIL multi_mixed e6: out=%b rise=%b fall=%b evt=%b, want 0110 0100 1000 1", dest_out, dest_rise, dest_fall, dest_evt);
        end
      end else if (dest_evt !== 1'b0 || dest_rise !== 4'b0000 || dest_fall !== 4'b0000) begin
        fails++;
        $display("FAIL multi_mixed_quiet e%0d: rise=%b fall=%b evt=%b, want 0", n, dest_rise, dest_fall, dest_evt);
      end
    end
  endtask

  task automatic test_reset_mid();
    settle(4'h0);
    src_in = 4'b1000;
    repeat (5) tick();
    dest_rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      tests++;
      if (dest_out !== 4'h0 || dest_rise !== 4'h0 || dest_fall !== 4'h0 || dest_evt !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_hold c%0d: out=%h rise=%h fall=%h evt=%b, want 0", n, dest_out, dest_rise, dest_fall, dest_evt);
      end
    end
    dest_rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      tests++;
      if (n < 6 && (dest_out !== 4'h0 || dest_rise !== 4'h0)) begin
        fails++;
        $display("FAIL reset_mid_early e%0d: out=%h rise=%h, want 0", n, dest_out, dest_rise);
      end
      if (n == 6 && (dest_out !== 4'b1000 || dest_rise !== 4'b1000 || dest_evt !== 1'b1)) begin
        fails++;
        $display("FAIL reset_mid_accept e6: out=%b rise=%b evt=%b, want 1000 1000 1", dest_out, dest_rise, dest_evt);
      end
    end
  endtask

  initial begin
    dest_rst = 1'b1;
    filt_en = 1'b1;
    src_in = 4'h0;
    test_reset();
    test_glitch();
    test_restart();
    test_bypass();
    test_multi();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdc_sync_filter.md
Name: cdc_sync_filter

Overview:
- Multi-channel synchroniser for asynchronous level inputs (pins, interrupt lines, status bits from other clock domains) into the dest_clk domain.
- Each channel has:
  - a DEST_SYNC_FF-deep synchroniser chain;
  - a per-channel glitch filter that passes a new level only after it is stable for FILTER_CNT cycles;
  - registered rise and fall event pulses.
- Used as the common front end for external/async signals feeding the core and peripherals.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- DEST_SYNC_FF, 2, synchroniser stages per channel (2..10).
- FILTER_CNT, 4, consecutive stable cycles required to accept a new level (1..255; 1 = no filtering).
- INIT, 1'b0, reset value of every synchroniser stage and of dest_out, applied to all channels.
- CNT_W, derived localparam = clog2(FILTER_CNT+1), filter counter width; not overridable.

Ports:
- dest_clk  input  1  destination clock; the only clock.
- dest_rst  input  1  reset, synchronous to dest_clk, active-high.
- filt_en  input  1  1 = glitch filter active; 0 = bypass (FILTER_CNT forced to 1).
- src_in  input  WIDTH  asynchronous level inputs; no timing relation to dest_clk.
- dest_out  output  WIDTH  filtered, synchronised level.
- dest_rise  output  WIDTH  one-cycle pulse, per channel, when dest_out goes 0->1.
- dest_fall  output  WIDTH  one-cycle pulse, per channel, when dest_out goes 1->0.
- dest_evt  output  1  OR-reduction of (dest_rise | dest_fall), registered in the same cycle as the pulses.

Behaviour:
- All state updates on the dest_clk rising edge. dest_rst has priority over everything.
- Reset values:
  - sync stages = INIT, dest_out = INIT, counters = 0;
  - dest_rise = dest_fall = dest_evt = 0.
- Sync chain per channel: stage0 <= src_in[i]; stage[k] <= stage[k-1]. The filter input is s = the last stage.
- Filter counter per channel:
  - s == dest_out: cnt <= 0.
  - s != dest_out and cnt+1 < EFF_CNT: cnt <= cnt+1.
  - s != dest_out and cnt+1 == EFF_CNT: dest_out <= s, cnt <= 0, and the matching edge pulse is set this cycle.
- EFF_CNT = FILTER_CNT when filt_en = 1, else 1.
- Latency: a src_in change captured at edge 0 appears on dest_out after edge DEST_SYNC_FF+EFF_CNT-1, i.e. DEST_SYNC_FF+EFF_CNT edges inclusive.
- Glitches:
  - A level at s lasting fewer than EFF_CNT cycles never reaches dest_out. Its counter returns to 0 when s matches dest_out again.
  - Any mismatch interrupted by a match restarts counting from 0. There is no accumulation across glitches.
- Pulses:
  - dest_rise[i]/dest_fall[i] are high for exactly one cycle, aligned with the first cycle of the new dest_out value.
  - They are 0 in all other cycles. Two consecutive pulses on one channel are impossible when EFF_CNT > 1.
  - With EFF_CNT = 1 a toggling s may produce pulses on consecutive cycles.
- Channels are fully independent. Simultaneous events on several channels give simultaneous pulses and a single dest_evt cycle.
- filt_en change mid-count: the counter is not cleared and the new EFF_CNT applies from the next edge.
  - 1->0 with a pending mismatch: dest_out updates on the next edge.
  - 0->1: counting continues; accept when cnt+1 == FILTER_CNT.
  - Counters never exceed FILTER_CNT-1.
- Reset mid-operation:
  - All state returns to reset values and the pending count is discarded.
  - No pulses are generated by reset assertion or release.
  - After release, src_in levels differing from INIT are accepted through the normal path and do pulse.
- Out-of-range parameters are a configuration error: generate-time $error.

Decomposition:
- No shared package types are needed. Parameter range limits (SYNC_FF_MIN=2, SYNC_FF_MAX=10, FILTER_CNT_MAX=255) go in the shared CDC constants include used by all synchroniser blocks.
- One sub-module, cdc_filter_chan:
  - contains a single channel's sync chain, counter and edge pulses;
  - takes parameters DEST_SYNC_FF, FILTER_CNT, INIT;
  - is instantiated WIDTH times in a generate loop.
- The top level holds only the generate loop and the dest_evt register.

Test Plan:
- Reset check (WIDTH=4, DEST_SYNC_FF=2, FILTER_CNT=4, INIT=0): hold dest_rst 3 cycles with src_in=4'hF -> dest_out=0, no pulses during reset. After release, dest_out=4'hF at edge 6 and dest_rise=4'hF for exactly one cycle.
- Glitch rejection: src_in[0] high for 3 cycles -> dest_out[0] stays 0, no pulse. High for 4 cycles -> dest_out[0]=1 after 6 edges and a single dest_rise[0].
- Restart: src_in[1] pattern 1,1,1,0,1,1,1,1 -> only the final run of 4 is accepted; exactly one rise, at edge 2+8.
- Bypass: filt_en=0, toggle src_in[2] every cycle -> dest_out[2] follows with a 2-edge delay, with rise/fall pulses every cycle. Set filt_en=1 mid-stream -> toggles are suppressed.
- Multi-channel: src_in 0->4'b1010 then 4'b1010->4'b0110 -> dest_rise/dest_fall show per-bit pulses on the same cycle; dest_evt is high one cycle per transition.
- Reset mid-count: src_in[3]=1, assert dest_rst after 3 filter cycles -> dest_out[3]=0, counter cleared. After release, acceptance takes a full 2+4 edges.
